// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the deframer state encoding, parity selector levels and the line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;

    // data_par is the XOR of all data bits; the XOR with the parity bit must match the selected sense.
    function automatic logic parity_error(input logic data_par, input logic pbit, input logic odd);
        return (data_par ^ pbit) != (odd ? PARITY_ODD : PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Character output channel of the receive deframer: valid/ready handshake plus error flags.
// master = deframer side, slave = consumer side.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_parity_err;
    logic                 out_frame_err;
    logic                 out_break;

    modport master (
        output out_data, out_valid, out_parity_err, out_frame_err, out_break,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_parity_err, out_frame_err, out_break,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw RX line; resets to the idle (high) level
// so no false start bit is seen coming out of reset.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{LINE_IDLE}};
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start detection, divider idle control, bit sampling on the
// divider strobe and a single-entry output buffer with a saturating overrun counter.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int OVR_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    input  logic                    cfg_parity_en,
    input  logic                    cfg_parity_odd,
    output logic                    div_idle,
    input  logic                    div_strobe,
    uart_rx_deframer_if.master      rx_out,
    output logic [OVR_CNT_BITS-1:0] ovr_count,
    input  logic                    ovr_clear
);

    localparam int CNT_W = $clog2(DATA_BITS);

    logic                    rx_s;
    rx_state_e               state_q;
    logic                    div_idle_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0]    shift_q;
    logic                    par_bit_q;
    logic                    par_err_q;

    logic [DATA_BITS-1:0]    data_q;
    logic                    valid_q;
    logic                    perr_q;
    logic                    ferr_q;
    logic                    brk_q;
    logic [OVR_CNT_BITS-1:0] ovr_q;

    logic                    stop_load;
    logic                    frame_err_d;
    logic                    break_d;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .rx_s_o (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_idle_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_s != LINE_IDLE) begin
                        state_q    <= ST_START;
                        div_idle_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (div_strobe) begin
                        if (rx_s == LINE_IDLE) begin
                            state_q    <= ST_IDLE;
                            div_idle_q <= 1'b1;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                            par_bit_q <= 1'b0;
                            par_err_q <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (div_strobe) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_q <= cfg_parity_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (div_strobe) begin
                        par_bit_q <= rx_s;
                        par_err_q <= parity_error(^shift_q, rx_s, cfg_parity_odd);
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (div_strobe) begin
                        div_idle_q <= 1'b1;
                        state_q    <= (rx_s == LINE_IDLE) ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line must go high before another start bit is accepted.
                    if (rx_s == LINE_IDLE) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    div_idle_q <= 1'b1;
                end
            endcase
        end
    end

    assign stop_load   = (state_q == ST_STOP) && div_strobe;
    assign frame_err_d = (rx_s != LINE_IDLE);
    assign break_d     = frame_err_d && (shift_q == '0) && !par_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else if (stop_load && (!valid_q || rx_out.out_ready)) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            perr_q  <= par_err_q;
            ferr_q  <= frame_err_d;
            brk_q   <= break_d;
        end else if (valid_q && rx_out.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Overruns drop the incoming character; the held one stays untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else if (ovr_clear) begin
            ovr_q <= '0;
        end else if (stop_load && valid_q && !rx_out.out_ready &&
                     (ovr_q != {OVR_CNT_BITS{1'b1}})) begin
            ovr_q <= ovr_q + OVR_CNT_BITS'(1);
        end
    end

    assign div_idle              = div_idle_q;
    assign rx_out.out_data       = data_q;
    assign rx_out.out_valid      = valid_q;
    assign rx_out.out_parity_err = perr_q;
    assign rx_out.out_frame_err  = ferr_q;
    assign rx_out.out_break      = brk_q;
    assign ovr_count             = ovr_q;

endmodule
